// File: rtl/ct_split_q.sv
// ct_split_q: flow-mapped eager-fork splitter; i_data/i_valid/i_flow/o_ready in, per-output o_data/o_flow/o_valid/i_ready out, o_drop_count of unknown flows
module ct_split_q #(
  parameter int NO = 2,
  parameter int WO = 8,
  parameter int NF = 1,
  parameter int WF = 1,
  parameter logic [NF*WF-1:0] FLOWS = '0,
  parameter logic [NF*NO-1:0] ENABLES = '0,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WO-1:0]    i_data,
  input  logic             i_valid,
  input  logic [WF-1:0]    i_flow,
  output logic             o_ready,
  output logic [NO*WO-1:0] o_data,
  output logic [NO*WF-1:0] o_flow,
  output logic [NO-1:0]    o_valid,
  input  logic [NO-1:0]    i_ready,
  output logic [15:0]      o_drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [NO-1:0] mask, full, push, pop;
  logic known, accept;
  always_comb begin
    mask = '0;
    known = 1'b0;
    for (int k = 0; k < NF; k++)
      if (FLOWS[WF*k +: WF] == i_flow) begin
        mask = mask | ENABLES[NO*k +: NO];
        known = 1'b1;
      end
  end
  assign o_ready = !reset && (!known || !(|(mask & full)));
  assign accept = i_valid && o_ready;
  assign push = (accept && known) ? mask : '0;
  assign pop = o_valid & i_ready;
  for (genvar i = 0; i < NO; i++) begin : g_q
    logic [WF+WO-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [CW-1:0] cnt;
    assign full[i] = cnt == CW'(DEPTH);
    assign o_valid[i] = cnt != '0;
    assign {o_flow[WF*i +: WF], o_data[WO*i +: WO]} = mem[rd];
    always_ff @(posedge clk)
      if (push[i]) mem[wr] <= {i_flow, i_data};
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        rd <= '0;
        wr <= '0;
        cnt <= '0;
      end else begin
        if (push[i]) wr <= wr + 1'b1;
        if (pop[i]) rd <= rd + 1'b1;
        cnt <= cnt + CW'(push[i]) - CW'(pop[i]);
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) o_drop_count <= '0;
    else if (accept && !known && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 1'b1;
endmodule
